// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad column scanner: drives one column low per dwell period, samples the rows,
// locks onto the first key found. Optional multi-row rejection: KEYPAD_MULTI_ROW_REJECT_EN.
module keypad_scanner #(
   parameter int SCAN_DIV = 48000
) (
   input  logic       int_osc,
   input  logic       reset,
   input  logic [3:0] row,
   output logic [3:0] col,
   output logic [7:0] key_val,
   output logic       key_pressed
);

   localparam int              CW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CW-1:0]   CNT_LAST = CW'(SCAN_DIV - 1);

   typedef enum logic {
      SCAN = 1'b0,
      HOLD = 1'b1
   } state_e;

   logic [3:0]    row_meta_q, row_s_q;
   logic [CW-1:0] cnt_q;
   state_e        state_q, state_d;
   logic [1:0]    ci_q, ci_d;
   logic [7:0]    key_val_q, key_val_d;
   logic          key_pressed_q, key_pressed_d;

   logic [3:0] rh;
   logic [3:0] hit_row;
   logic [3:0] col_oh;
   logic       sample;
   logic       take;

   assign rh      = ~row_s_q;
   assign hit_row = rh & (~rh + 4'd1);   // isolate lowest set bit
   assign col_oh  = 4'b0001 << ci_q;
   assign sample  = (cnt_q == CNT_LAST);

`ifdef KEYPAD_MULTI_ROW_REJECT_EN
   assign take = (rh != 4'd0) && ((rh & (rh - 4'd1)) == 4'd0);
`else
   assign take = (rh != 4'd0);
`endif

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge int_osc or negedge reset) begin
      if (!reset) begin
         row_meta_q    <= 4'b1111;
         row_s_q       <= 4'b1111;
         cnt_q         <= '0;
         state_q       <= SCAN;
         ci_q          <= 2'd0;
         key_val_q     <= 8'h00;
         key_pressed_q <= 1'b0;
      end else begin
         row_meta_q    <= row;
         row_s_q       <= row_meta_q;
         cnt_q         <= sample ? '0 : cnt_q + CW'(1);
         state_q       <= state_d;
         ci_q          <= ci_d;
         key_val_q     <= key_val_d;
         key_pressed_q <= key_pressed_d;
      end
   end

   // NOTE: every output of this block is given a default first so no latch is inferred.
   always_comb begin
      state_d       = state_q;
      ci_d          = ci_q;
      key_val_d     = key_val_q;
      key_pressed_d = key_pressed_q;
      if (sample) begin
         case (state_q)
            SCAN: begin
               if (take) begin
                  key_val_d     = {hit_row, col_oh};
                  key_pressed_d = 1'b1;
                  state_d       = HOLD;
               end else begin
                  ci_d = ci_q + 2'd1;
               end
            end
            HOLD: begin
               // Only the latched row matters; other rows on this column are ignored.
               if ((rh & key_val_q[7:4]) == 4'd0) begin
                  key_val_d     = 8'h00;
                  key_pressed_d = 1'b0;
                  ci_d          = ci_q + 2'd1;
                  state_d       = SCAN;
               end
            end
            default: state_d = SCAN;
         endcase
      end
   end

   assign col         = ~col_oh;
   assign key_val     = key_val_q;
   assign key_pressed = key_pressed_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: keypad matrix model, per-sample-point reference model,
// directed scenarios followed by randomized press/release sessions.
module tb_keypad_scanner;

   localparam int DIV = 8;

   logic        int_osc = 1'b0;
   logic        reset;
   logic [3:0]  row;
   logic [3:0]  col;
   logic [7:0]  key_val;
   logic        key_pressed;

   logic [15:0] pressed;   // bit r*4+c = key at (row r, column c) held down
   logic [3:0]  glitch;    // forces a row low regardless of columns

   int total = 0;
   int bad   = 0;

   // reference model state, in key/column terms
   int          edge_n;
   logic [3:0]  hist[$];
   int          m_ci;
   bit          m_hold;
   logic [7:0]  m_key;

   keypad_scanner #(.SCAN_DIV(DIV)) dut (
      .int_osc     (int_osc),
      .reset       (reset),
      .row         (row),
      .col         (col),
      .key_val     (key_val),
      .key_pressed (key_pressed)
   );

   always #5 int_osc = ~int_osc;

   always_comb begin
      row = 4'b1111;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (pressed[r*4+c] && !col[c]) row[r] = 1'b0;
         end
         if (glitch[r]) row[r] = 1'b0;
      end
   end

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      edge_n = 0;
      hist   = {4'hF, 4'hF};
      m_ci   = 0;
      m_hold = 0;
      m_key  = 8'h00;
   endtask

   // Decision at a sample point, from the rows seen two edges earlier.
   task automatic model_sample(input logic [3:0] rh);
      bit take;
      take = (rh != 4'd0);
`ifdef KEYPAD_MULTI_ROW_REJECT_EN
      if ($countones(rh) > 1) take = 0;
`endif
      if (!m_hold) begin
         if (take) begin
            for (int r = 3; r >= 0; r--) if (rh[r]) m_key[7:4] = 4'(1 << r);
            m_key[3:0] = 4'(1 << m_ci);
            m_hold = 1;
         end else begin
            m_ci = (m_ci + 1) % 4;
         end
      end else if ((rh & m_key[7:4]) == 4'd0) begin
         m_key  = 8'h00;
         m_hold = 0;
         m_ci   = (m_ci + 1) % 4;
      end
   endtask

   task automatic step();
      logic [3:0] used;
      #1;
      hist.push_back(row);
      @(posedge int_osc);
      #1;
      used = hist[hist.size()-3];
      if (edge_n % DIV == DIV - 1) model_sample(~used);
      edge_n++;
      while (hist.size() > 3) void'(hist.pop_front());
      check("col", {4'h0, col}, {4'h0, 4'(~(4'b0001 << m_ci))});
      check("key_val", key_val, m_key);
      check("key_pressed", {7'd0, key_pressed}, {7'd0, m_hold});
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   task automatic wait_hold(input bit want, input int budget);
      int n;
      n = 0;
      while (m_hold != want && n < budget) begin
         step();
         n++;
      end
      check("wait_bound", {7'd0, key_pressed}, {7'd0, want});
   endtask

   task automatic sync_to_sample();
      while (edge_n % DIV != 0) step();
   endtask

   initial begin
      int r, c;
      pressed = 16'h0;
      glitch  = 4'h0;
      reset   = 1'b0;
      model_reset();

      // reset state
      repeat (3) @(posedge int_osc);
      #1;
      check("rst_col", {4'h0, col}, 8'h0E);
      check("rst_key_val", key_val, 8'h00);
      check("rst_key_pressed", {7'd0, key_pressed}, 8'h00);
      @(negedge int_osc);
      reset = 1'b1;
      model_reset();

      // free scan over two full rotations
      run(8 * DIV);

      // single press at (row0, col0)
      pressed[0] = 1'b1;
      wait_hold(1, 5 * DIV);
      check("single_key_val", key_val, 8'h11);
      check("single_col", {4'h0, col}, 8'h0E);
      run(2 * DIV);
      pressed[0] = 1'b0;
      wait_hold(0, 3 * DIV);
      check("single_rel_val", key_val, 8'h00);
      check("single_rel_col", {4'h0, col}, 8'h0D);

      // held key (3,3) with a second key (2,0)
      pressed[15] = 1'b1;
      wait_hold(1, 5 * DIV);
      check("held_first", key_val, 8'h88);
      pressed[8] = 1'b1;
      run(3 * DIV);
      check("held_unchanged", key_val, 8'h88);
      pressed[15] = 1'b0;
      wait_hold(0, 3 * DIV);
      check("held_released", key_val, 8'h00);
      wait_hold(1, 5 * DIV);
      check("second_key", key_val, 8'h41);
      pressed = 16'h0;
      wait_hold(0, 3 * DIV);

      // same column double press: rows 1 and 3 on column 1
      pressed[5]  = 1'b1;
      pressed[13] = 1'b1;
      run(5 * DIV);
`ifdef KEYPAD_MULTI_ROW_REJECT_EN
      check("double_reject", {7'd0, key_pressed}, 8'h00);
`else
      check("double_lowest", key_val, 8'h22);
`endif
      pressed = 16'h0;
      wait_hold(0, 3 * DIV);

      // one-cycle glitch well away from the sample point
      sync_to_sample();
      run(3);
      glitch = 4'b0001;
      step();
      glitch = 4'h0;
      run(2 * DIV);
      check("glitch_ignored", {7'd0, key_pressed}, 8'h00);

      // randomized press/release sessions
      for (int it = 0; it < 24; it++) begin
         r = $urandom_range(0, 3);
         c = $urandom_range(0, 3);
         pressed = 16'h0;
         pressed[r*4+c] = 1'b1;
         if ($urandom_range(0, 3) == 0) pressed[$urandom_range(0, 15)] = 1'b1;
         run($urandom_range(1, 6 * DIV));
         if ($urandom_range(0, 3) == 0) begin
            glitch = 4'(1 << $urandom_range(0, 3));
            step();
            glitch = 4'h0;
         end
         pressed = 16'h0;
         run($urandom_range(1, 3 * DIV));
      end
      wait_hold(0, 3 * DIV);

      // asynchronous reset in the middle of HOLD
      pressed[6] = 1'b1;
      wait_hold(1, 5 * DIV);
      check("pre_reset_val", key_val, 8'h24);
      #1;
      reset = 1'b0;
      #1;
      check("async_rst_pressed", {7'd0, key_pressed}, 8'h00);
      check("async_rst_col", {4'h0, col}, 8'h0E);
      check("async_rst_val", key_val, 8'h00);
      pressed = 16'h0;
      @(negedge int_osc);
      reset = 1'b1;
      model_reset();
      run(2 * DIV);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
